// File: rtl/crc_engine.sv
// Bit-serial-per-beat CRC engine: one DATA_W-bit beat per cycle, IDLE/RUN/DONE framing.
// Define CRC_ENGINE_CHECK_EN to add the registered crc_ok residue-check output.
module crc_engine #(
    parameter int          CRC_W   = 32,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
    parameter int          DATA_W  = 8,
    parameter bit          REFLECT = 1'b1,
    parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
    input  logic              clk_100Mz,
    input  logic              rst_n,
    input  logic              start,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              din_last,
    output logic              busy,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid
`ifdef CRC_ENGINE_CHECK_EN
    ,
    output logic              crc_ok
`endif
);

    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_W  = XOR_OUT[CRC_W-1:0];

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CRC_W-1:0] crc_reg, crc_nx, seed;
    logic             accept;

    // Whole beat folded in one cycle; REFLECT selects which end of the beat goes first.
    function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 0; i < DATA_W; i++) begin
            fb = r[CRC_W-1] ^ (REFLECT ? d[i] : d[DATA_W-1-i]);
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
        return r;
    endfunction

    // start in RUN aborts and reseeds, so a beat arriving with start always sees INIT.
    assign accept = (state == RUN) || (state == IDLE && start);
    assign seed   = start ? INIT_W : crc_reg;

    always_comb begin
        state_nx = state;
        crc_nx   = crc_reg;
        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    crc_nx   = seed;
                    state_nx = RUN;
                    if (din_valid) begin
                        crc_nx = crc_beat(seed, din);
                        if (din_last) state_nx = DONE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mz) begin
        if (!rst_n) begin
            state     <= IDLE;
            crc_reg   <= INIT_W;
            crc_out   <= '0;
            crc_valid <= 1'b0;
`ifdef CRC_ENGINE_CHECK_EN
            crc_ok    <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            crc_reg   <= crc_nx;
            crc_valid <= (state == DONE);
            if (state == DONE) begin
                crc_out <= (REFLECT ? bitrev(crc_reg) : crc_reg) ^ XOR_W;
`ifdef CRC_ENGINE_CHECK_EN
                crc_ok  <= (crc_reg == RESIDUE[CRC_W-1:0]);
`endif
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: directed CRC-32 vectors plus random framed traffic
// compared against a byte-wise CRC reference model.
module tb_crc_engine;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n, start, din_valid, din_last;
    logic [7:0]  din;
    logic        busy0, busy1, crc_valid0, crc_valid1;
    logic [31:0] crc_out0, crc_out1;
`ifdef CRC_ENGINE_CHECK_EN
    logic        crc_ok0, crc_ok1;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int np0    = 0;
    int np1    = 0;

    crc_engine dut (
        .clk_100Mz(clk), .rst_n(rst_n), .start(start), .din_valid(din_valid),
        .din(din), .din_last(din_last), .busy(busy0), .crc_out(crc_out0),
        .crc_valid(crc_valid0)
`ifdef CRC_ENGINE_CHECK_EN
        , .crc_ok(crc_ok0)
`endif
    );

    crc_engine #(.REFLECT(1'b0)) dut_msb (
        .clk_100Mz(clk), .rst_n(rst_n), .start(start), .din_valid(din_valid),
        .din(din), .din_last(din_last), .busy(busy1), .crc_out(crc_out1),
        .crc_valid(crc_valid1)
`ifdef CRC_ENGINE_CHECK_EN
        , .crc_ok(crc_ok1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (crc_valid0) np0 <= np0 + 1;
        if (crc_valid1) np1 <= np1 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Raw register as the engine would hold it: the reflected table-free CRC-32
    // runs on a mirrored register, so mirror it back for the MSB-first view.
    function automatic logic [31:0] model_raw(input bq_t d, input bit refl);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[k]) begin
            if (refl) begin
                c = c ^ {24'h0, d[k]};
                for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end else begin
                c = c ^ {d[k], 24'h0};
                for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
            end
        end
        return refl ? rev32(c) : c;
    endfunction

    function automatic logic [31:0] model_out(input bq_t d, input bit refl);
        logic [31:0] raw;
        raw = model_raw(d, refl);
        return (refl ? rev32(raw) : raw) ^ 32'hFFFFFFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bq_t d, input int max_gap, input bit start_with_beat);
        if (!start_with_beat) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        foreach (d[i]) begin
            if (i > 0) repeat ($urandom_range(max_gap, 0)) tick();
            start     = start_with_beat && (i == 0);
            din_valid = 1'b1;
            din       = d[i];
            din_last  = (i == d.size() - 1);
            tick();
            start     = 1'b0;
            din_valid = 1'b0;
            din_last  = 1'b0;
        end
    endtask

    // Called #1 after the last-beat edge: expects the pulse exactly one cycle later.
    task automatic result(input string tag, input bq_t d);
        int p0, p1;
        p0 = np0;
        p1 = np1;
        chk({tag, "_busy_done"}, busy0, 1'b1);
        chk({tag, "_vld_early"}, crc_valid0, 1'b0);
        tick();
        chk({tag, "_vld0"}, crc_valid0, 1'b1);
        chk({tag, "_vld1"}, crc_valid1, 1'b1);
        chk({tag, "_crc_lsb"}, crc_out0, model_out(d, 1'b1));
        chk({tag, "_crc_msb"}, crc_out1, model_out(d, 1'b0));
`ifdef CRC_ENGINE_CHECK_EN
        chk({tag, "_ok"}, crc_ok0, model_raw(d, 1'b1) == 32'hC704DD7B);
`endif
        tick();
        chk({tag, "_vld_off"}, crc_valid0, 1'b0);
        chk({tag, "_busy_idle"}, busy0, 1'b0);
        chk({tag, "_pulses0"}, np0 - p0, 1);
        chk({tag, "_pulses1"}, np1 - p1, 1);
    endtask

    initial begin
        bq_t s9, fr, part;
        int  p0;

        for (int i = 0; i < 9; i++) s9.push_back(8'(8'h31 + i));
        rst_n = 1'b0; start = 1'b0; din_valid = 1'b0; din_last = 1'b0; din = 8'h00;
        tick(); tick();
        chk("rst_busy", busy0, 1'b0);
        chk("rst_vld", crc_valid0, 1'b0);
        chk("rst_crc", crc_out0, 32'h0);
`ifdef CRC_ENGINE_CHECK_EN
        chk("rst_ok", crc_ok0, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // Check value, both bit orders, start on the first beat.
        send(s9, 0, 1'b1);
        result("check", s9);
        chk("check_const_lsb", crc_out0, 32'hCBF43926);
        chk("check_const_msb", crc_out1, 32'hFC891918);

        repeat (5) tick();
        chk("hold_crc", crc_out0, 32'hCBF43926);

        // Frame with appended CRC, then with a corrupted final byte.
        fr = s9;
        fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
        send(fr, 0, 1'b1);
        result("resid_good", fr);
`ifdef CRC_ENGINE_CHECK_EN
        chk("resid_good_const", crc_ok0, 1'b1);
`endif
        fr[12] = 8'hCA;
        send(fr, 0, 1'b0);
        result("resid_bad", fr);
`ifdef CRC_ENGINE_CHECK_EN
        chk("resid_bad_const", crc_ok0, 1'b0);
`endif

        // Random valid gaps.
        send(s9, 5, 1'b0);
        result("gaps", s9);
        chk("gaps_const", crc_out0, 32'hCBF43926);

        // Abort mid-frame with start, then a clean frame.
        p0 = np0;
        part = {8'hDE, 8'hAD, 8'hBE};
        start = 1'b1;
        foreach (part[i]) begin
            din_valid = 1'b1; din = part[i];
            tick();
            start = 1'b0;
        end
        din_valid = 1'b0;
        tick();
        send(s9, 2, 1'b1);
        result("abort", s9);
        chk("abort_const", crc_out0, 32'hCBF43926);
        chk("abort_pulses", np0 - p0, 1);

        // start/din_valid during DONE must be ignored.
        fr = {8'hA5, 8'h3C};
        send(fr, 0, 1'b1);
        start = 1'b1; din_valid = 1'b1; din = 8'h55; din_last = 1'b1;
        tick();
        start = 1'b0; din_valid = 1'b0; din_last = 1'b0;
        chk("done_ign_vld", crc_valid0, 1'b1);
        chk("done_ign_crc", crc_out0, model_out(fr, 1'b1));
        chk("done_ign_busy", busy0, 1'b0);
        tick();
        chk("done_ign_vld_off", crc_valid0, 1'b0);

        // Single-beat frame: start + last together.
        fr = {8'($urandom_range(255, 0))};
        send(fr, 0, 1'b1);
        result("single", fr);

        for (int k = 0; k < 8; k++) begin
            fr = {};
            repeat ($urandom_range(12, 1)) fr.push_back(8'($urandom_range(255, 0)));
            send(fr, 3, k[0]);
            result($sformatf("rnd%0d", k), fr);
            repeat ($urandom_range(3, 0)) tick();
        end

        // Reset mid-frame, then stray beats without start.
        p0 = np0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din_valid = 1'b1; din = 8'(8'h31 + i);
            tick();
            start = 1'b0;
        end
        din_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_vld", crc_valid0, 1'b0);
        chk("midrst_crc", crc_out0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din_valid = 1'b1; din = 8'(8'h41 + i); din_last = (i == 3);
            tick();
        end
        din_valid = 1'b0; din_last = 1'b0;
        repeat (3) tick();
        chk("midrst_ign_busy", busy0, 1'b0);
        chk("midrst_ign_crc", crc_out0, 32'h0);
        chk("midrst_pulses", np0 - p0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
